// File: rtl/pa_riscv.sv
// Shared RISC-V definitions for the multicycle datapath: opcodes, ALU ops, controller states and select encodings.
// MULTICYCLE_CTRL_JAL_EN adds the JAL controller state.
package pa_riscv;

  typedef enum logic [6:0] {
    I     = 7'b0000011,
    S     = 7'b0100011,
    R     = 7'b0110011,
    I_ALU = 7'b0010011,
    B     = 7'b1100011,
    J     = 7'b1101111
  } ty_opcode;

  localparam logic [3:0] ADD = 4'b0000;
  localparam logic [3:0] SUB = 4'b1000;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BEQ
`ifdef MULTICYCLE_CTRL_JAL_EN
    ,
    JAL
`endif
  } ty_ctrl_state;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10
  } ty_aluSrcA;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } ty_aluSrcB;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10
  } ty_resultSel;

  // isBeq marks the one state whose PC load comes from the live zero flag.
  typedef struct packed {
    logic        pcWrite;
    logic        addrSel;
    logic        irWrite;
    logic        memWrite;
    logic        regWrite;
    ty_aluSrcA   srcA;
    ty_aluSrcB   srcB;
    ty_resultSel resultSel;
    logic        retire;
    logic        isBeq;
  } ty_ctrl_out;

  function automatic ty_ctrl_out moore_decode(input ty_ctrl_state s);
    ty_ctrl_out o;
    o           = '0;
    o.srcA      = SRCA_PC;
    o.srcB      = SRCB_RS2;
    o.resultSel = RES_ALUOUT;
    case (s)
      FETCH: begin
        o.irWrite   = 1'b1;
        o.srcB      = SRCB_FOUR;
        o.resultSel = RES_ALURESULT;
        o.pcWrite   = 1'b1;
      end
      DECODE: begin
        o.srcA = SRCA_OLDPC;
        o.srcB = SRCB_IMM;
      end
      MEMADR: begin
        o.srcA = SRCA_RS1;
        o.srcB = SRCB_IMM;
      end
      MEMREAD: o.addrSel = 1'b1;
      MEMWB: begin
        o.resultSel = RES_DATA;
        o.regWrite  = 1'b1;
        o.retire    = 1'b1;
      end
      MEMWRITE: begin
        o.addrSel  = 1'b1;
        o.memWrite = 1'b1;
        o.retire   = 1'b1;
      end
      EXECUTER: o.srcA = SRCA_RS1;
      EXECUTEI: begin
        o.srcA = SRCA_RS1;
        o.srcB = SRCB_IMM;
      end
      ALUWB: begin
        o.regWrite = 1'b1;
        o.retire   = 1'b1;
      end
      BEQ: begin
        o.srcA   = SRCA_RS1;
        o.retire = 1'b1;
        o.isBeq  = 1'b1;
      end
`ifdef MULTICYCLE_CTRL_JAL_EN
      JAL: begin
        o.srcA    = SRCA_OLDPC;
        o.srcB    = SRCB_FOUR;
        o.pcWrite = 1'b1;
      end
`endif
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Bundle between the instruction register / datapath and the multicycle controller.
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       i_operand;
  logic [2:0]       i_funct3;
  logic             i_funct7bit5;
  logic             i_zero;
  logic             o_pcWriteEn;
  logic             o_addrSel;
  logic             o_irWriteEn;
  logic             o_memWriteEn;
  logic             o_regWriteEn;
  logic [1:0]       o_aluSrcASel;
  logic [1:0]       o_aluSrcBSel;
  logic [1:0]       o_resultSel;
  logic [3:0]       o_aluLogicOperation;
  logic             o_retire;
  logic             o_illegal;
  logic [CNT_W-1:0] o_retireCount;

  modport master (
    output i_operand, i_funct3, i_funct7bit5, i_zero,
    input  o_pcWriteEn, o_addrSel, o_irWriteEn, o_memWriteEn, o_regWriteEn,
           o_aluSrcASel, o_aluSrcBSel, o_resultSel, o_aluLogicOperation,
           o_retire, o_illegal, o_retireCount
  );

  modport slave (
    input  i_operand, i_funct3, i_funct7bit5, i_zero,
    output o_pcWriteEn, o_addrSel, o_irWriteEn, o_memWriteEn, o_regWriteEn,
           o_aluSrcASel, o_aluSrcBSel, o_resultSel, o_aluLogicOperation,
           o_retire, o_illegal, o_retireCount
  );
endinterface

// File: rtl/alu_op_decoder.sv
// Selects the shared ALU operation from the controller state and the instruction funct fields.
module alu_op_decoder
  import pa_riscv::*;
(
  input  ty_ctrl_state i_state,
  input  logic [2:0]   i_funct3,
  input  logic         i_funct7bit5,
  output logic [3:0]   o_aluOp
);

  // Immediate ALU ops ignore funct7 so ADDI never becomes SUB.
  always_comb begin
    o_aluOp = ADD;
    case (i_state)
      EXECUTER: o_aluOp = {i_funct7bit5, i_funct3};
      EXECUTEI: o_aluOp = {1'b0, i_funct3};
      BEQ:      o_aluOp = SUB;
      default:  o_aluOp = ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RISC-V datapath with retired-instruction counter.
// Define MULTICYCLE_CTRL_JAL_EN to add JAL support; otherwise opcode J is illegal.
module multicycle_controller
  import pa_riscv::*;
#(
  parameter int CNT_W = 32
) (
  input logic                   i_clk,
  input logic                   i_rst,
  multicycle_controller_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ty_ctrl_state     r_state;
  ty_ctrl_state     w_next;
  ty_ctrl_out       r_out;
  logic [CNT_W-1:0] r_retireCount;
  logic             w_legal;
  logic [3:0]       w_aluOp;

  always_comb begin
    w_legal = 1'b0;
    case (bus.i_operand)
      I, S, R, I_ALU, B: w_legal = 1'b1;
`ifdef MULTICYCLE_CTRL_JAL_EN
      J:                 w_legal = 1'b1;
`endif
      default:           w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH: w_next = DECODE;
      DECODE: begin
        case (bus.i_operand)
          I, S:    w_next = MEMADR;
          R:       w_next = EXECUTER;
          I_ALU:   w_next = EXECUTEI;
          B:       w_next = BEQ;
`ifdef MULTICYCLE_CTRL_JAL_EN
          J:       w_next = JAL;
`endif
          default: w_next = FETCH;
        endcase
      end
      MEMADR:   w_next = (bus.i_operand == I) ? MEMREAD : MEMWRITE;
      MEMREAD:  w_next = MEMWB;
      EXECUTER: w_next = ALUWB;
      EXECUTEI: w_next = ALUWB;
`ifdef MULTICYCLE_CTRL_JAL_EN
      JAL:      w_next = ALUWB;
`endif
      default:  w_next = FETCH;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= FETCH;
      r_out         <= moore_decode(FETCH);
      r_retireCount <= '0;
    end else begin
      r_state <= w_next;
      r_out   <= moore_decode(w_next);
      if (r_out.retire) r_retireCount <= r_retireCount + CNT_ONE;
    end
  end

  alu_op_decoder u_aluOpDecoder (
    .i_state      (r_state),
    .i_funct3     (bus.i_funct3),
    .i_funct7bit5 (bus.i_funct7bit5),
    .o_aluOp      (w_aluOp)
  );

  assign bus.o_pcWriteEn         = !i_rst && (r_out.pcWrite || (r_out.isBeq && bus.i_zero));
  assign bus.o_addrSel           = !i_rst && r_out.addrSel;
  assign bus.o_irWriteEn         = !i_rst && r_out.irWrite;
  assign bus.o_memWriteEn        = !i_rst && r_out.memWrite;
  assign bus.o_regWriteEn        = !i_rst && r_out.regWrite;
  assign bus.o_aluSrcASel        = i_rst ? 2'b00 : r_out.srcA;
  assign bus.o_aluSrcBSel        = i_rst ? 2'b00 : r_out.srcB;
  assign bus.o_resultSel         = i_rst ? 2'b00 : r_out.resultSel;
  assign bus.o_aluLogicOperation = i_rst ? 4'b0000 : w_aluOp;
  assign bus.o_retire            = !i_rst && r_out.retire;
  assign bus.o_illegal           = !i_rst && (r_state == DECODE) && !w_legal;
  assign bus.o_retireCount       = r_retireCount;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-instruction-class cycle tables plus a retire-count model, random and directed.
module tb_multicycle_controller;

  localparam int C_LOAD = 0, C_STORE = 1, C_RALU = 2, C_IALU = 3, C_BR = 4, C_JAL = 5, C_ILL = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_count = '0;

  multicycle_controller_if #(.CNT_W(32)) bus ();

  multicycle_controller #(.CNT_W(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  wire [16:0] obs = {bus.o_pcWriteEn, bus.o_addrSel, bus.o_irWriteEn, bus.o_memWriteEn,
                     bus.o_regWriteEn, bus.o_aluSrcASel, bus.o_aluSrcBSel, bus.o_resultSel,
                     bus.o_aluLogicOperation, bus.o_retire, bus.o_illegal};

  function automatic int classify(input logic [6:0] opc);
    case (opc)
      7'h03:   return C_LOAD;
      7'h23:   return C_STORE;
      7'h33:   return C_RALU;
      7'h13:   return C_IALU;
      7'h63:   return C_BR;
      7'h6F: begin
`ifdef MULTICYCLE_CTRL_JAL_EN
        return C_JAL;
`else
        return C_ILL;
`endif
      end
      default: return C_ILL;
    endcase
  endfunction

  function automatic int instr_len(input int cls);
    case (cls)
      C_LOAD:  return 5;
      C_BR:    return 3;
      C_ILL:   return 2;
      default: return 4;
    endcase
  endfunction

  // Field order: pcWrite addrSel irWrite memWrite regWrite srcA srcB resultSel aluOp retire illegal
  function automatic logic [16:0] pack(input logic pc, input logic as, input logic ir,
                                       input logic mw, input logic rw, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] r,
                                       input logic [3:0] op, input logic ret, input logic ill);
    return {pc, as, ir, mw, rw, a, b, r, op, ret, ill};
  endfunction

  function automatic logic [16:0] exp_vec(input int cls, input int k, input logic [2:0] f3,
                                          input logic f7, input logic z);
    if (k == 0)
      return pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 2'd2, 4'd0, 1'b0, 1'b0);
    if (k == 1)
      return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 2'd0, 4'd0, 1'b0, cls == C_ILL);
    case (cls)
      C_LOAD: begin
        if (k == 2) return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 2'd0, 4'd0, 1'b0, 1'b0);
        if (k == 3) return pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0);
        return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 4'd0, 1'b1, 1'b0);
      end
      C_STORE: begin
        if (k == 2) return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 2'd0, 4'd0, 1'b0, 1'b0);
        return pack(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 4'd0, 1'b1, 1'b0);
      end
      C_RALU: begin
        if (k == 2) return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, {f7, f3}, 1'b0, 1'b0);
        return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 4'd0, 1'b1, 1'b0);
      end
      C_IALU: begin
        if (k == 2) return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 2'd0, {1'b0, f3}, 1'b0, 1'b0);
        return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 4'd0, 1'b1, 1'b0);
      end
      C_BR:
        return pack(z, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 4'b1000, 1'b1, 1'b0);
      C_JAL: begin
        if (k == 2) return pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 2'd0, 4'd0, 1'b0, 1'b0);
        return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 4'd0, 1'b1, 1'b0);
      end
      default: return '0;
    endcase
  endfunction

  // zmode: 0/1 fixed zero flag, 2 random per cycle. rst_at: cycle index to assert reset (-1 none).
  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                           input int zmode, input int rst_at, input string name);
    int          cls;
    int          n;
    logic        z;
    logic [16:0] e;
    cls = classify(opc);
    n   = instr_len(cls);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst              = (k == rst_at);
      bus.i_operand    = opc;
      bus.i_funct3     = f3;
      bus.i_funct7bit5 = f7;
      if (zmode == 2) z = 1'($urandom_range(0, 1));
      else            z = (zmode == 1);
      bus.i_zero = z;
      #1;
      e = (k == rst_at) ? 17'd0 : exp_vec(cls, k, f3, f7, z);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s opc=%h cycle %0d outputs got %b expected %b", name, opc, k, obs, e);
      end
      checks++;
      if (bus.o_retireCount !== exp_count) begin
        errors++;
        $display("FAIL %s_count opc=%h cycle %0d got %0d expected %0d", name, opc, k,
                 bus.o_retireCount, exp_count);
      end
      if (k == rst_at) begin
        exp_count = '0;
        break;
      end
      if (e[1]) exp_count = exp_count + 32'd1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      bus.i_operand    = 7'($urandom_range(0, 127));
      bus.i_funct3     = 3'($urandom_range(0, 7));
      bus.i_funct7bit5 = 1'($urandom_range(0, 1));
      bus.i_zero       = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (obs !== 17'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got %b expected 0", c, obs);
      end
      checks++;
      if (bus.o_retireCount !== 32'd0) begin
        errors++;
        $display("FAIL reset_count cycle %0d got %0d expected 0", c, bus.o_retireCount);
      end
    end
    exp_count = '0;
  endtask

  task automatic test_load();
    run_instr(7'h03, 3'b010, 1'b0, 2, -1, "load");
  endtask

  task automatic test_store();
    run_instr(7'h23, 3'b010, 1'b1, 2, -1, "store");
  endtask

  task automatic test_ralu();
    run_instr(7'h33, 3'b000, 1'b1, 2, -1, "ralu_sub");
    run_instr(7'h13, 3'b111, 1'b1, 2, -1, "ialu_andi");
  endtask

  task automatic test_branch();
    run_instr(7'h63, 3'b000, 1'b0, 1, -1, "beq_taken");
    run_instr(7'h63, 3'b000, 1'b0, 0, -1, "beq_not_taken");
  endtask

  task automatic test_illegal();
    run_instr(7'h7F, 3'b000, 1'b0, 2, -1, "illegal");
    run_instr(7'h6F, 3'b000, 1'b0, 2, -1, "jal");
    run_instr(7'h03, 3'b000, 1'b0, 2, -1, "after_illegal");
  endtask

  task automatic test_reset_mid();
    run_instr(7'h03, 3'b010, 1'b0, 2, 3, "reset_memread");
    run_instr(7'h03, 3'b010, 1'b0, 2, 4, "reset_on_retire");
    run_instr(7'h33, 3'b100, 1'b0, 2, -1, "after_reset");
  endtask

  task automatic test_random();
    logic [6:0] opc;
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 7))
        0:       opc = 7'h03;
        1:       opc = 7'h23;
        2:       opc = 7'h33;
        3:       opc = 7'h13;
        4:       opc = 7'h63;
        5:       opc = 7'h6F;
        default: opc = 7'($urandom_range(0, 127));
      endcase
      run_instr(opc, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2, -1, "random");
    end
  endtask

  initial begin
    bus.i_operand    = '0;
    bus.i_funct3     = '0;
    bus.i_funct7bit5 = 1'b0;
    bus.i_zero       = 1'b0;
    test_reset();
    test_load();
    test_store();
    test_ralu();
    test_branch();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
